// File: rtl/fifo_pkg.sv
// Shared constants and types for the FIFO read-side stream adapter.
package fifo_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned RD_BUF_DEPTH   = 3;
    localparam int unsigned RD_PTR_W       = 2;
    localparam int unsigned OCC_W          = 2;

    typedef logic [RD_PTR_W-1:0] rd_ptr_t;
    typedef logic [OCC_W-1:0]    occ_t;

    // Circular pointer increment, wrapping at RD_BUF_DEPTH.
    function automatic rd_ptr_t ptr_inc(input rd_ptr_t p);
        return (p == rd_ptr_t'(RD_BUF_DEPTH - 1)) ? rd_ptr_t'(0) : p + rd_ptr_t'(1);
    endfunction

endpackage

// File: rtl/fifo_rd_buf.sv
// Three-entry circular holding buffer absorbing the FIFO read latency.
module fifo_rd_buf
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output occ_t                  occ
);

    logic [DATA_WIDTH-1:0] mem_q [RD_BUF_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [RD_BUF_DEPTH];
    rd_ptr_t               wr_ptr_q, wr_ptr_d;
    rd_ptr_t               rd_ptr_q, rd_ptr_d;
    occ_t                  occ_q, occ_d;
    logic                  rd_fire;

    assign rd_fire = rd_en && (occ_q != occ_t'(0));

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (rd_fire) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        // Simultaneous write and read leaves occupancy unchanged.
        case ({wr_en, rd_fire})
            2'b10:   occ_d = occ_q + occ_t'(1);
            2'b01:   occ_d = occ_q - occ_t'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < RD_BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign occ     = occ_q;

`ifndef SYNTHESIS
    occ_overflow_a: assert property (@(posedge clk) disable iff (!rst)
        !(wr_en && !rd_fire && (occ_q == occ_t'(RD_BUF_DEPTH))));
`endif

endmodule

// File: rtl/fifo_stream_reader.sv
// Pops a synchronous FIFO and presents its words as a valid/ready stream.
// Optional handshake counter output enabled by FIFO_STREAM_READER_COUNT_EN.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready
`ifdef FIFO_STREAM_READER_COUNT_EN
    ,
    output logic [15:0]           pop_count
`endif
);

    localparam int unsigned SUM_W = OCC_W + 1;

    logic              inflight_q, inflight_d;
    occ_t              occ;
    logic              pop;
    logic [SUM_W-1:0]  committed;

    // Issue depends only on registered state and fifo_empty, never on m_ready.
    assign committed  = SUM_W'(occ) + SUM_W'(inflight_q);
    assign fifo_rd_en = !fifo_empty && (committed < SUM_W'(RD_BUF_DEPTH));
    assign m_valid    = (occ != occ_t'(0));
    assign pop        = m_valid && m_ready;

    always_comb begin
        inflight_d = fifo_rd_en;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    fifo_rd_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rd_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (inflight_q),
        .wr_data (fifo_data),
        .rd_en   (pop),
        .rd_data (m_data),
        .occ     (occ)
    );

`ifdef FIFO_STREAM_READER_COUNT_EN
    logic [15:0] pop_count_q, pop_count_d;

    always_comb begin
        pop_count_d = pop_count_q;
        if (pop) begin
            pop_count_d = pop_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pop_count_q <= '0;
        end else begin
            pop_count_q <= pop_count_d;
        end
    end

    assign pop_count = pop_count_q;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: queue-based FIFO environment and stream model.
module tb_fifo_stream_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_rd_en;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ready;
`ifdef FIFO_STREAM_READER_COUNT_EN
    logic [15:0] pop_count;
`endif

    always #5 clk = ~clk;

    fifo_stream_reader #(.DATA_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_ready    (m_ready)
`ifdef FIFO_STREAM_READER_COUNT_EN
        ,
        .pop_count  (pop_count)
`endif
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // FIFO environment: registered read, cleared on reset.
    logic [7:0] fifo_mem [4096];
    int         wr_idx = 0;
    int         rd_idx = 0;

    assign fifo_empty = (rd_idx == wr_idx);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_idx    <= wr_idx;
            fifo_data <= '0;
        end else if (fifo_rd_en && (rd_idx != wr_idx)) begin
            fifo_data <= fifo_mem[12'(rd_idx)];
            rd_idx    <= rd_idx + 1;
        end
    end

    // Reference model: words waiting in the FIFO, one in flight, up to three held.
    logic [7:0] src_q [$];
    logic [7:0] out_q [$];
    logic       pending = 1'b0;
    logic [7:0] pending_word = '0;
    int         hs_total = 0;
    int         cyc = 0;
    int         rd_log [$];
    int         hs_cyc [$];
    logic [7:0] hs_dat [$];

    task automatic push(input logic [7:0] w);
        fifo_mem[12'(wr_idx)] = w;
        wr_idx = wr_idx + 1;
        src_q.push_back(w);
    endtask

    function automatic logic busy();
        return (src_q.size() != 0) || (out_q.size() != 0) || pending;
    endfunction

    always @(negedge clk) begin
        logic rd_exp;
        #2;
        cyc++;
        if (!rst) begin
            src_q.delete();
            out_q.delete();
            pending  = 1'b0;
            hs_total = 0;
        end else begin
            rd_exp = (src_q.size() != 0) && ((out_q.size() + int'(pending)) < 3);
            chk("fifo_rd_en", 32'(fifo_rd_en), 32'(rd_exp));
            chk("m_valid", 32'(m_valid), 32'(out_q.size() != 0));
            if (out_q.size() != 0) chk("m_data", 32'(m_data), 32'(out_q[0]));
`ifdef FIFO_STREAM_READER_COUNT_EN
            chk("pop_count", 32'(pop_count), hs_total & 32'hFFFF);
`endif
            if (fifo_rd_en) rd_log.push_back(cyc);
            if (m_valid && m_ready) begin
                hs_cyc.push_back(cyc);
                hs_dat.push_back(m_data);
            end
            if ((out_q.size() != 0) && m_ready) begin
                void'(out_q.pop_front());
                hs_total++;
            end
            if (pending) out_q.push_back(pending_word);
            if (rd_exp) pending_word = src_q.pop_front();
            pending = rd_exp;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(input string name, input int budget);
        for (int i = 0; i < budget && busy(); i++) @(negedge clk);
        step(2);
        chk(name, 32'(busy()), 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int h;
        logic [7:0] words [20];
        int pushed;

        rst     = 1'b0;
        m_ready = 1'b1;
        step(3);
        rst = 1'b1;

        // Reset then idle.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #3;
            chk("idle_rd_en", 32'(fifo_rd_en), 32'd0);
            chk("idle_valid", 32'(m_valid), 32'd0);
            chk("idle_data", 32'(m_data), 32'd0);
        end

        // Single word: valid exactly two cycles after the pop pulse.
        s = rd_log.size();
        h = hs_cyc.size();
        @(negedge clk);
        push(8'hA5);
        step(6);
        chk("single_pops", 32'(rd_log.size() - s), 32'd1);
        chk("single_hs", 32'(hs_cyc.size() - h), 32'd1);
        if (hs_cyc.size() > h && rd_log.size() > s) begin
            chk("single_data", 32'(hs_dat[h]), 32'hA5);
            chk("single_latency", 32'(hs_cyc[h] - rd_log[s]), 32'd2);
        end

        // Streaming: 20 words, one per cycle.
        s = rd_log.size();
        h = hs_cyc.size();
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            words[i] = 8'($urandom);
            push(words[i]);
        end
        drain("stream_drain", 100);
        chk("stream_pops", 32'(rd_log.size() - s), 32'd20);
        chk("stream_hs", 32'(hs_cyc.size() - h), 32'd20);
        if (rd_log.size() - s == 20 && hs_cyc.size() - h == 20) begin
            chk("stream_pop_span", 32'(rd_log[s+19] - rd_log[s]), 32'd19);
            chk("stream_hs_span", 32'(hs_cyc[h+19] - hs_cyc[h]), 32'd19);
            for (int i = 0; i < 20; i++) chk("stream_order", 32'(hs_dat[h+i]), 32'(words[i]));
        end

        // Backpressure: exactly three pops while stalled.
        s = rd_log.size();
        h = hs_cyc.size();
        @(negedge clk);
        m_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            words[i] = 8'($urandom);
            push(words[i]);
        end
        for (int i = 0; i < 8; i++) begin
            #3;
            if (i >= 2) chk("bp_hold_data", 32'(m_data), 32'(words[0]));
            if (i >= 2) chk("bp_hold_valid", 32'(m_valid), 32'd1);
            @(negedge clk);
        end
        chk("bp_stall_pops", 32'(rd_log.size() - s), 32'd3);
        m_ready = 1'b1;
        drain("bp_drain", 100);
        chk("bp_hs", 32'(hs_cyc.size() - h), 32'd10);
        if (hs_cyc.size() - h == 10) begin
            for (int i = 0; i < 10; i++) chk("bp_order", 32'(hs_dat[h+i]), 32'(words[i]));
        end

        // Mid-stream asynchronous reset with two words buffered.
        @(negedge clk);
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(8'(8'h11 * (i + 1)));
        step(3);
        #3;
        chk("mid_pre_valid", 32'(m_valid), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_valid", 32'(m_valid), 32'd0);
        chk("mid_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("mid_data", 32'(m_data), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst     = 1'b1;
        m_ready = 1'b1;
        h = hs_dat.size();
        push(8'h3C);
        drain("mid_drain", 50);
        chk("mid_hs", 32'(hs_dat.size() - h), 32'd1);
        if (hs_dat.size() > h) chk("mid_first", 32'(hs_dat[h]), 32'h3C);

        // Randomized traffic and backpressure.
        h = hs_dat.size();
        pushed = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            m_ready = ($urandom_range(0, 3) != 0) || (i > 300);
            if ($urandom_range(0, 1) == 0) begin
                push(8'($urandom));
                pushed++;
            end
            if ($urandom_range(0, 7) == 0) begin
                push(8'($urandom));
                pushed++;
            end
        end
        m_ready = 1'b1;
        drain("rand_drain", 2000);
        chk("rand_count", 32'(hs_dat.size() - h), 32'(pushed));

`ifdef FIFO_STREAM_READER_COUNT_EN
        // Handshake counter wrap.
        @(negedge clk);
        rst = 1'b0;
        step(2);
        rst = 1'b1;
        m_ready = 1'b1;
        for (int n = 0; hs_total < 70000 && n < 70100; n++) begin
            @(negedge clk);
            push(8'(n));
        end
        m_ready = 1'b0;
        #3;
        chk("count_wrap", 32'(pop_count), 32'd4464);
`endif

        step(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
